// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the timing generator and renderers
interface vga_timing_gen_if #(
   parameter int CW      = 10,
   parameter int FRAME_W = 8
);
   logic               enable;
   logic               p_tick;
   logic               hsync;
   logic               vsync;
   logic               video_on;
   logic [CW-1:0]      x;
   logic [CW-1:0]      y;
   logic               sol;
   logic               sof;
   logic [FRAME_W-1:0] frame_count;

   modport master (
      input  enable,
      output p_tick, hsync, vsync, video_on, x, y, sol, sof, frame_count
   );

   modport slave (
      output enable,
      input  p_tick, hsync, vsync, video_on, x, y, sol, sof, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator (pixel tick, syncs, coordinates, strobes)
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 2,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int CW        = 10,
   parameter int FRAME_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0]    H_ACT    = CW'(H_DISPLAY);
   localparam logic [CW-1:0]    V_ACT    = CW'(V_DISPLAY);
   localparam logic [CW-1:0]    HS_START = CW'(H_DISPLAY + H_FRONT);
   localparam logic [CW-1:0]    HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CW-1:0]    VS_START = CW'(V_DISPLAY + V_FRONT);
   localparam logic [CW-1:0]    VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic             HS_ON    = (HSYNC_POL != 0);
   localparam logic             VS_ON    = (VSYNC_POL != 0);

   logic [DIV_W-1:0]   div;
   logic [CW-1:0]      x_q;
   logic [CW-1:0]      y_q;
   logic [CW-1:0]      x_nxt;
   logic [CW-1:0]      y_nxt;
   logic               tick;
   logic               line_end;
   logic               frame_end;
   logic               hs_act_nxt;
   logic               vs_act_nxt;
   logic               von_nxt;
   logic               hsync_q;
   logic               vsync_q;
   logic               video_on_q;
   logic               sol_q;
   logic               sof_q;
   logic [FRAME_W-1:0] frame_q;

   assign tick      = vga.enable && (div == DIV_LAST);
   assign line_end  = (x_q == H_LAST);
   assign frame_end = line_end && (y_q == V_LAST);

   always_comb begin
      x_nxt = line_end ? '0 : x_q + CW'(1);
      y_nxt = y_q;
      if (line_end) begin
         y_nxt = (y_q == V_LAST) ? '0 : y_q + CW'(1);
      end
   end

   // Decode the coordinate we are about to enter so the registered flags line up with x/y.
   assign hs_act_nxt = (x_nxt >= HS_START) && (x_nxt <= HS_END);
   assign vs_act_nxt = (y_nxt >= VS_START) && (y_nxt <= VS_END);
   assign von_nxt    = (x_nxt < H_ACT) && (y_nxt < V_ACT);

   always_ff @(posedge clk) begin
      if (reset) begin
         div        <= '0;
         x_q        <= H_LAST;
         y_q        <= V_LAST;
         hsync_q    <= ~HS_ON;
         vsync_q    <= ~VS_ON;
         video_on_q <= 1'b0;
         sol_q      <= 1'b0;
         sof_q      <= 1'b0;
         frame_q    <= '0;
      end else begin
         if (vga.enable) begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
         end
         if (tick) begin
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            hsync_q    <= hs_act_nxt ? HS_ON : ~HS_ON;
            vsync_q    <= vs_act_nxt ? VS_ON : ~VS_ON;
            video_on_q <= von_nxt;
            sol_q      <= (x_nxt == '0);
            sof_q      <= (x_nxt == '0) && (y_nxt == '0);
            if (frame_end) begin
               frame_q <= frame_q + FRAME_W'(1);
            end
         end
      end
   end

   assign vga.p_tick      = tick;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = video_on_q;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.sol         = sol_q;
   assign vga.sof         = sof_q;
   assign vga.frame_count = frame_q;

endmodule
